// File: rtl/rfetch_stage_mp.sv
// Register-fetch stage: multi-port regfile with writeback bypass, valid/ready stage register with flush,
// and refresh of held operands. Optional macro RFETCH_REGFILE_RESET_EN clears the regfile on reset.
module rfetch_stage_mp #(
  parameter int unsigned WIDTH_P  = 32,
  parameter int unsigned REGS_P   = 32,
  parameter int unsigned NUM_RS_P = 2,
  parameter int unsigned NUM_WB_P = 2,
  parameter int unsigned META_W_P = 128,
  localparam int unsigned REG_W   = $clog2(REGS_P)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_v_i,
  input  logic                         in_v_i,
  output logic                         in_ready_o,
  input  logic [NUM_RS_P*REG_W-1:0]    in_rs_i,
  input  logic [META_W_P-1:0]          in_meta_i,
  output logic                         out_v_o,
  input  logic                         out_ready_i,
  output logic [NUM_RS_P*REG_W-1:0]    out_rs_o,
  output logic [NUM_RS_P*WIDTH_P-1:0]  out_rs_data_o,
  output logic [META_W_P-1:0]          out_meta_o,
  input  logic [NUM_WB_P-1:0]          wb_v_i,
  input  logic [NUM_WB_P*REG_W-1:0]    wb_rd_i,
  input  logic [NUM_WB_P*WIDTH_P-1:0]  wb_data_i
);

  logic [WIDTH_P-1:0] regs     [REGS_P];
  logic [REG_W-1:0]   wb_rd    [NUM_WB_P];
  logic [WIDTH_P-1:0] wb_dat   [NUM_WB_P];
  logic [REG_W-1:0]   rs_in    [NUM_RS_P];
  logic [REG_W-1:0]   rs_held  [NUM_RS_P];
  logic [WIDTH_P-1:0] rd_val   [NUM_RS_P];
  logic [WIDTH_P-1:0] hold_val [NUM_RS_P];
  logic [WIDTH_P-1:0] data_q   [NUM_RS_P];
  logic               accept;

  for (genvar g = 0; g < NUM_WB_P; g++) begin : g_wb
    assign wb_rd[g]  = wb_rd_i[g*REG_W +: REG_W];
    assign wb_dat[g] = wb_data_i[g*WIDTH_P +: WIDTH_P];
  end

  for (genvar g = 0; g < NUM_RS_P; g++) begin : g_rs
    assign rs_in[g]   = in_rs_i[g*REG_W +: REG_W];
    assign rs_held[g] = out_rs_o[g*REG_W +: REG_W];
    assign out_rs_data_o[g*WIDTH_P +: WIDTH_P] = data_q[g];
  end

  assign in_ready_o = !rst_i && !flush_v_i && (!out_v_o || out_ready_i);
  assign accept     = in_v_i && in_ready_o;

  // Regfile writes; later loop iterations win, so the highest-index port has priority.
`ifdef RFETCH_REGFILE_RESET_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < REGS_P; r++) regs[r] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WB_P; k++)
        if (wb_v_i[k] && (wb_rd[k] != '0)) regs[wb_rd[k]] <= wb_dat[k];
    end
  end
`else
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NUM_WB_P; k++)
      if (wb_v_i[k] && (wb_rd[k] != '0)) regs[wb_rd[k]] <= wb_dat[k];
  end
`endif

  // Operand read with bypass, and refresh of held operands, both highest-index-wins.
  always_comb begin
    for (int unsigned k = 0; k < NUM_RS_P; k++) begin
      rd_val[k]   = '0;
      hold_val[k] = data_q[k];
      if (rs_in[k] != '0) rd_val[k] = regs[rs_in[k]];
      for (int unsigned j = 0; j < NUM_WB_P; j++) begin
        if (wb_v_i[j] && (wb_rd[j] != '0) && (wb_rd[j] == rs_in[k]))   rd_val[k]   = wb_dat[j];
        if (wb_v_i[j] && (wb_rd[j] != '0) && (wb_rd[j] == rs_held[k])) hold_val[k] = wb_dat[j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_v_o    <= 1'b0;
      out_rs_o   <= '0;
      out_meta_o <= '0;
      for (int unsigned k = 0; k < NUM_RS_P; k++) data_q[k] <= '0;
    end else if (flush_v_i) begin
      out_v_o <= 1'b0;
    end else if (accept) begin
      out_v_o    <= 1'b1;
      out_rs_o   <= in_rs_i;
      out_meta_o <= in_meta_i;
      for (int unsigned k = 0; k < NUM_RS_P; k++) data_q[k] <= rd_val[k];
    end else if (out_v_o && out_ready_i) begin
      out_v_o <= 1'b0;
    end else if (out_v_o) begin
      for (int unsigned k = 0; k < NUM_RS_P; k++) data_q[k] <= hold_val[k];
    end
  end

endmodule

// File: tb/tb_rfetch_stage_mp.sv
// Directed table-driven bench for rfetch_stage_mp (default parameters).
module tb_rfetch_stage_mp;

  logic         clk_i = 1'b0;
  logic         rst_i, flush_v_i, in_v_i, in_ready_o, out_v_o, out_ready_i;
  logic [9:0]   in_rs_i, out_rs_o, wb_rd_i;
  logic [127:0] in_meta_i, out_meta_o;
  logic [63:0]  out_rs_data_o, wb_data_i;
  logic [1:0]   wb_v_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  rfetch_stage_mp dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_v_i(flush_v_i),
    .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_rs_i(in_rs_i), .in_meta_i(in_meta_i),
    .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_rs_o(out_rs_o),
    .out_rs_data_o(out_rs_data_o), .out_meta_o(out_meta_o),
    .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i)
  );

  typedef struct {
    logic        in_v; logic out_ready; logic flush;
    logic [4:0]  rs0; logic [4:0] rs1;
    logic [31:0] tag;
    logic [1:0]  wb_v; logic [4:0] rd0; logic [4:0] rd1;
    logic [31:0] d0; logic [31:0] d1;
    logic        e_ready; logic e_v;
    logic [31:0] e_d0; logic [31:0] e_d1; logic [31:0] e_tag;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_v_i = 1'b0; out_ready_i = 1'b1; flush_v_i = 1'b0;
    in_rs_i = '0; in_meta_i = '0; wb_v_i = '0; wb_rd_i = '0; wb_data_i = '0;
  endtask

  initial begin
    //             in out fl rs0 rs1 tag   wbv    rd0 rd1 d0          d1           rdy v  ed0         ed1         etag
    vecs[0]  = '{1'b0,1'b1,1'b0, 0, 0, 0,  2'b01,  5, 0, 32'hDEAD,  32'h0,       1'b1,1'b0, 0,          0,          0};
    vecs[1]  = '{1'b1,1'b1,1'b0, 5, 0, 1,  2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b1, 32'hDEAD,   0,          1};
    vecs[2]  = '{1'b0,1'b1,1'b0, 0, 0, 0,  2'b10,  0, 7, 32'h0,     32'h1,       1'b1,1'b0, 0,          0,          0};
    vecs[3]  = '{1'b1,1'b1,1'b0, 7, 5, 3,  2'b11,  7, 7, 32'h9999,  32'h1234,    1'b1,1'b1, 32'h1234,   32'hDEAD,   3};
    vecs[4]  = '{1'b0,1'b1,1'b0, 0, 0, 0,  2'b11,  3, 3, 32'hAA,    32'hBB,      1'b1,1'b0, 0,          0,          0};
    vecs[5]  = '{1'b1,1'b1,1'b0, 3, 7, 5,  2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b1, 32'hBB,     32'h1234,   5};
    vecs[6]  = '{1'b0,1'b1,1'b0, 0, 0, 0,  2'b11,  0, 9, 32'hFFFF,  32'h11,      1'b1,1'b0, 0,          0,          0};
    vecs[7]  = '{1'b1,1'b1,1'b0, 0, 0, 7,  2'b10,  0, 0, 32'h0,     32'hEEEE,    1'b1,1'b1, 0,          0,          7};
    vecs[8]  = '{1'b1,1'b1,1'b0, 9, 3, 8,  2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b1, 32'h11,     32'hBB,     8};
    vecs[9]  = '{1'b1,1'b0,1'b0, 1, 1, 9,  2'b00,  0, 0, 32'h0,     32'h0,       1'b0,1'b1, 32'h11,     32'hBB,     8};
    vecs[10] = '{1'b0,1'b0,1'b0, 0, 0, 0,  2'b01,  9, 0, 32'h55,    32'h0,       1'b0,1'b1, 32'h55,     32'hBB,     8};
    vecs[11] = '{1'b1,1'b0,1'b0, 2, 2, 11, 2'b00,  0, 0, 32'h0,     32'h0,       1'b0,1'b1, 32'h55,     32'hBB,     8};
    vecs[12] = '{1'b0,1'b1,1'b0, 0, 0, 0,  2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b0, 0,          0,          0};
    vecs[13] = '{1'b1,1'b1,1'b0, 3, 5, 13, 2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b1, 32'hBB,     32'hDEAD,   13};
    vecs[14] = '{1'b1,1'b0,1'b1, 5, 9, 14, 2'b00,  0, 0, 32'h0,     32'h0,       1'b0,1'b0, 0,          0,          0};
    vecs[15] = '{1'b1,1'b0,1'b0, 5, 9, 14, 2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b1, 32'hDEAD,   32'h55,     14};
    vecs[16] = '{1'b0,1'b1,1'b0, 0, 0, 0,  2'b00,  0, 0, 32'h0,     32'h0,       1'b1,1'b0, 0,          0,          0};

    idle();
    rst_i = 1'b1;
    in_v_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ready", 128'(in_ready_o), 128'(1'b0));
    chk("reset_out_v", 128'(out_v_o), 128'(1'b0));
    chk("reset_data", 128'(out_rs_data_o), 128'(0));
    chk("reset_rs", 128'(out_rs_o), 128'(0));
    chk("reset_meta", out_meta_o, 128'(0));
    rst_i = 1'b0;
    idle();

    // Directed table: writeback, bypass, conflict, x0, hold refresh, flush.
    for (int i = 0; i < 17; i++) begin
      in_v_i      = vecs[i].in_v;
      out_ready_i = vecs[i].out_ready;
      flush_v_i   = vecs[i].flush;
      in_rs_i     = {vecs[i].rs1, vecs[i].rs0};
      in_meta_i   = {4{vecs[i].tag}};
      wb_v_i      = vecs[i].wb_v;
      wb_rd_i     = {vecs[i].rd1, vecs[i].rd0};
      wb_data_i   = {vecs[i].d1, vecs[i].d0};
      #1;
      chk($sformatf("v%0d_ready", i), 128'(in_ready_o), 128'(vecs[i].e_ready));
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d_out_v", i), 128'(out_v_o), 128'(vecs[i].e_v));
      if (vecs[i].e_v) begin
        chk($sformatf("v%0d_d0", i), 128'(out_rs_data_o[31:0]), 128'(vecs[i].e_d0));
        chk($sformatf("v%0d_d1", i), 128'(out_rs_data_o[63:32]), 128'(vecs[i].e_d1));
        chk($sformatf("v%0d_meta", i), out_meta_o, {4{vecs[i].e_tag}});
      end
    end

    // Back-to-back: one word per cycle with x10 bypassed from wb0 each cycle.
    idle();
    for (int i = 0; i < 8; i++) begin
      in_v_i    = 1'b1;
      in_rs_i   = {5'd10, 5'd5};
      in_meta_i = {4{32'(100 + i)}};
      wb_v_i    = 2'b01;
      wb_rd_i   = {5'd0, 5'd10};
      wb_data_i = {32'h0, 32'(i + 1)};
      #1;
      chk($sformatf("b2b%0d_ready", i), 128'(in_ready_o), 128'(1'b1));
      @(posedge clk_i);
      #1;
      chk($sformatf("b2b%0d_out_v", i), 128'(out_v_o), 128'(1'b1));
      chk($sformatf("b2b%0d_meta", i), out_meta_o, {4{32'(100 + i)}});
      chk($sformatf("b2b%0d_d1", i), 128'(out_rs_data_o[63:32]), 128'(i + 1));
      chk($sformatf("b2b%0d_d0", i), 128'(out_rs_data_o[31:0]), 128'(32'hDEAD));
      chk($sformatf("b2b%0d_rs", i), 128'(out_rs_o), 128'({5'd10, 5'd5}));
    end
    idle();
    @(posedge clk_i);
    #1;
    chk("b2b_drain", 128'(out_v_o), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
